roberto_uc: RTL
===============

Name: roberto_uc

Overview:
- Control unit for the three-sensor ultrasonic ranging datapath.
- Each cycle it:
  - triggers a simultaneous measurement on all three HC-SR04 interfaces;
  - waits for all three to finish, or for a timeout;
  - sequences twelve ASCII characters to the 7E1 serial transmitter (3 sensors × 3 BCD digits + '#');
  - waits a fixed interval, then repeats while enabled.
- Drives the datapath's clears, measure strobe, character selects and transmit start, and consumes its done flags.

Parameters:
- INTERVALO, 50_000_000: clock cycles in the inter-frame wait (1 s at 50 MHz).
- TIMEOUT_MEDIDA, 2_000_000: clock cycles to wait for all sensor done flags before proceeding (40 ms).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- ligar  in  1  level enable for continuous operation
- pronto_medida1  in  1  sensor 1 measurement done (pulse or level)
- pronto_medida2  in  1  sensor 2 measurement done
- pronto_medida3  in  1  sensor 3 measurement done
- pronto_serial  in  1  transmitter idle/done level
- zera  out  1  one-cycle clear to sensor interfaces and transmitter
- medir  out  1  one-cycle measure strobe to all three sensors
- partida_tx  out  1  one-cycle transmit start
- sel_sensor  out  2  character source: 11 = sensor 1, 10 = sensor 2, 01 = sensor 3, 00 = none
- sel_digito  out  2  character within sensor: 11 = hundreds, 10 = tens, 01 = units, 00 = '#'
- ocupado  out  1  high in every state except inicial
- timeout  out  1  sticky: last measurement ended by timeout; cleared at next medir
- db_estado  out  4  current state code

Behaviour:
- All outputs are Moore, decoded from registered state. Counters are registered and cleared by reset.
- Reset (any state, any cycle, including mid-frame) forces on the next edge:
  - state = inicial;
  - counters = 0;
  - sticky flags = 0;
  - outputs: zera = medir = partida_tx = ocupado = timeout = 0, sel_sensor = 00, sel_digito = 00, db_estado = 0.
- States, with db_estado code:
  - inicial (0): idle. ligar = 1 → preparacao.
  - preparacao (1): zera = 1 for one cycle; clear sensor/digit counters and done flags → medida.
  - medida (2): medir = 1 for one cycle; clear timeout and the timeout counter → aguarda_medida.
  - aguarda_medida (3):
    - Each pronto_medidaN sets sticky flag N.
    - All three flags set → transmite.
    - Otherwise the counter reaches TIMEOUT_MEDIDA−1 → set timeout, go to transmite.
    - Flags set in the same cycle count toward completion.
  - transmite (4): partida_tx = 1 for one cycle → espera_tx.
  - espera_tx (5):
    - Rising edge of pronto_serial (registered previous value 0, current value 1) → proximo.
    - A level already high on entry is ignored.
  - proximo (6): advance sel_digito 11→10→01→00.
    - Was 00: reset to 11 and advance sel_sensor 11→10→01.
    - sel_sensor was 01 and sel_digito was 00 (12th character done) → espera_intervalo.
    - Otherwise → transmite.
  - espera_intervalo (7): count to INTERVALO−1.
    - ligar = 1 → preparacao.
    - ligar = 0 → inicial.
- sel_sensor and sel_digito:
  - Enter transmite for the first character of a frame as 11/11.
  - Stay stable from transmite through espera_tx.
  - Read 00/00 in inicial.
- ligar is sampled only in inicial and at the end of espera_intervalo. Deasserting mid-frame completes the current frame.
- Latency: ligar rising at edge k gives zera at k+1, medir at k+2 (relative to the registered state).
- Counter widths: $clog2 of the parameter, minimum 1 bit. No wrap inside a state, because the counter is cleared on state entry.

Test Plan:
- Reset mid-frame: assert reset while in espera_tx → next edge state = 0, all outputs 0; ligar held high → preparacao resumes one cycle after reset release.
- Normal frame (INTERVALO = 20, TIMEOUT_MEDIDA = 50):
  - Stimulus: ligar = 1; all three pronto_medida pulse 10 cycles after medir; model transmitter drops pronto_serial for 8 cycles after each partida_tx.
  - Required response: exactly 12 partida_tx pulses with (sel_sensor, sel_digito) = (11,11), (11,10), (11,01), (11,00), (10,11) … (01,00); then 20 cycles in state 7; then a new zera.
- Timeout: sensor 3 never reports done → transmite entered exactly 50 cycles after leaving medida; timeout = 1 throughout the frame; timeout cleared at the next medir.
- Stale ready: pronto_serial held high on entry to espera_tx with no rising edge → controller stays in state 5 until a 0→1 transition occurs.
- Disable mid-frame: ligar dropped after the 3rd character → all 12 characters still sent, then state returns to 0 after the interval and ocupado = 0.
- Simultaneous events: all three pronto_medida asserted in the same cycle as the timeout counter's terminal count → timeout stays 0 and state goes to transmite.

Source files
------------

// File: rtl/roberto_uc.sv
// Control unit for the three-sensor ultrasonic ranging datapath: triggers all sensors,
// waits for completion or timeout, streams twelve characters to the 7E1 transmitter, then idles.
module roberto_uc #(
  parameter int INTERVALO      = 50_000_000,
  parameter int TIMEOUT_MEDIDA = 2_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       pronto_medida1,
  input  logic       pronto_medida2,
  input  logic       pronto_medida3,
  input  logic       pronto_serial,
  output logic       zera,
  output logic       medir,
  output logic       partida_tx,
  output logic [1:0] sel_sensor,
  output logic [1:0] sel_digito,
  output logic       ocupado,
  output logic       timeout,
  output logic [3:0] db_estado
);

  // state            | meaning
  // inicial          | idle, waiting for ligar
  // preparacao       | clear datapath, select first character
  // medida           | one-cycle measure strobe, arm timeout timer
  // aguarda_medida   | collect done flags until all three or timeout
  // transmite        | one-cycle transmit start for the selected character
  // espera_tx        | wait for a fresh 0->1 on pronto_serial
  // proximo          | advance character select, detect end of frame
  // espera_intervalo | inter-frame wait, then repeat or go idle
  typedef enum logic [3:0] {
    INICIAL          = 4'd0,
    PREPARACAO       = 4'd1,
    MEDIDA           = 4'd2,
    AGUARDA_MEDIDA   = 4'd3,
    TRANSMITE        = 4'd4,
    ESPERA_TX        = 4'd5,
    PROXIMO          = 4'd6,
    ESPERA_INTERVALO = 4'd7
  } estado_t;

  localparam int IW = (INTERVALO > 1) ? $clog2(INTERVALO) : 1;
  localparam int TW = (TIMEOUT_MEDIDA > 1) ? $clog2(TIMEOUT_MEDIDA) : 1;
  localparam logic [IW-1:0] INT_CARGA = IW'(INTERVALO - 1);
  localparam logic [TW-1:0] MED_CARGA = TW'(TIMEOUT_MEDIDA - 1);

  estado_t estado, prox;

  logic [IW-1:0] cnt_int;
  logic [TW-1:0] cnt_med;
  logic          flag1, flag2, flag3;
  logic          serial_ant;
  logic          todos_prontos, fim_medida, borda_serial, ultimo_char, fim_intervalo;

  // Done pulses arriving in the same cycle count toward completion.
  assign todos_prontos = (flag1 | pronto_medida1) & (flag2 | pronto_medida2) &
                         (flag3 | pronto_medida3);
  assign fim_medida    = (cnt_med == '0);
  assign fim_intervalo = (cnt_int == '0);
  assign borda_serial  = ~serial_ant & pronto_serial;
  assign ultimo_char   = (sel_sensor == 2'b01) && (sel_digito == 2'b00);

  assign ocupado   = (estado != INICIAL);
  assign db_estado = estado;

  always_ff @(posedge clock) begin
    if (reset) estado <= INICIAL;
    else       estado <= prox;
  end

  always_comb begin
    prox       = estado;
    zera       = 1'b0;
    medir      = 1'b0;
    partida_tx = 1'b0;
    case (estado)
      INICIAL:          if (ligar) prox = PREPARACAO;
      PREPARACAO: begin
        zera = 1'b1;
        prox = MEDIDA;
      end
      MEDIDA: begin
        medir = 1'b1;
        prox  = AGUARDA_MEDIDA;
      end
      AGUARDA_MEDIDA:   if (todos_prontos || fim_medida) prox = TRANSMITE;
      TRANSMITE: begin
        partida_tx = 1'b1;
        prox       = ESPERA_TX;
      end
      ESPERA_TX:        if (borda_serial) prox = PROXIMO;
      PROXIMO:          prox = ultimo_char ? ESPERA_INTERVALO : TRANSMITE;
      ESPERA_INTERVALO: if (fim_intervalo) prox = ligar ? PREPARACAO : INICIAL;
      default:          prox = INICIAL;
    endcase
  end

  // Timers are down-counters loaded on the cycle before the state that uses them.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_int    <= '0;
      cnt_med    <= '0;
      flag1      <= 1'b0;
      flag2      <= 1'b0;
      flag3      <= 1'b0;
      timeout    <= 1'b0;
      serial_ant <= 1'b0;
      sel_sensor <= 2'b00;
      sel_digito <= 2'b00;
    end else begin
      serial_ant <= pronto_serial;
      case (estado)
        PREPARACAO: begin
          flag1      <= 1'b0;
          flag2      <= 1'b0;
          flag3      <= 1'b0;
          sel_sensor <= 2'b11;
          sel_digito <= 2'b11;
        end
        MEDIDA: begin
          timeout <= 1'b0;
          cnt_med <= MED_CARGA;
        end
        AGUARDA_MEDIDA: begin
          flag1 <= flag1 | pronto_medida1;
          flag2 <= flag2 | pronto_medida2;
          flag3 <= flag3 | pronto_medida3;
          if (!todos_prontos) begin
            if (fim_medida) timeout <= 1'b1;
            else            cnt_med <= cnt_med - 1'b1;
          end
        end
        PROXIMO: begin
          if (ultimo_char) begin
            sel_sensor <= 2'b00;
            sel_digito <= 2'b00;
            cnt_int    <= INT_CARGA;
          end else if (sel_digito == 2'b00) begin
            sel_digito <= 2'b11;
            sel_sensor <= sel_sensor - 2'd1;
          end else begin
            sel_digito <= sel_digito - 2'd1;
          end
        end
        ESPERA_INTERVALO: if (!fim_intervalo) cnt_int <= cnt_int - 1'b1;
        default: ;
      endcase
    end
  end

endmodule
